// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch front end: the instruction
// width, the default reset PC, the NOP encoding shown when nothing is valid,
// the FSM state type and the {pc, instr} entry layout.
package if_fetch_unit_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// fetch_fifo
// Small synchronous FIFO used twice by the fetch unit (pending-PC queue and
// output buffer). The head entry is read straight from the register array so
// it is visible the cycle after it was written.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   flush             drop all contents (wins over push and pop)
//   push, push_data   write one entry (accepted when not full, or when popping)
//   pop               remove the head entry (ignored when empty)
//   head_data         current head entry
//   full, empty       status flags
//   count             number of stored entries
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic             do_push, do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_reg[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch front end. Owns the PC, issues in-order word fetches to
// instruction memory, pairs each returned word with its PC and presents
// {pc, instr} downstream with valid/ready flow control. Redirects discard the
// wrong path: buffered entries are flushed and responses still in flight are
// counted and dropped when they come back.
// Ports:
//   clk, rst_n                      clock / asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel
//   imem_rsp_valid/data             in-order response channel
//   redirect_valid/pc               taken branch / jump / exception target
//   out_valid/ready, out_pc/instr   IF/ID boundary
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t   state_reg, state_next;
    logic [31:0]    pc_reg, pc_next;
    logic [CW-1:0]  inflight_reg, inflight_next;
    logic [CW-1:0]  drop_reg, drop_next;

    logic           req_fire;
    logic           rsp_seen, rsp_accept, rsp_drop;
    logic [CW:0]    credit_used;

    logic [31:0]    pend_head;
    logic           pend_full, pend_empty;
    logic [CW-1:0]  pend_count;

    fetch_entry_t   obuf_head, obuf_push_data;
    logic           obuf_full, obuf_empty, obuf_pop;
    logic [CW-1:0]  obuf_count;

    logic           unused_status;

    // Words fetched but not yet consumed downstream may never exceed DEPTH;
    // this is what guarantees the output buffer always has room for a response.
    assign credit_used = {1'b0, inflight_reg} + {1'b0, obuf_count};

    // A response with nothing in flight can only be a leftover from before a
    // reset; ignoring it keeps the counters from underflowing.
    assign rsp_seen   = imem_rsp_valid && (inflight_reg != '0);
    assign rsp_accept = rsp_seen && !redirect_valid && (drop_reg == '0);
    assign rsp_drop   = rsp_seen && !redirect_valid && (drop_reg != '0);

    assign req_fire      = imem_req_valid && imem_req_ready;
    assign imem_req_addr = pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_PC;
            inflight_reg <= '0;
            drop_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        imem_req_valid = 1'b0;
        case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                state_next     = ST_RUN;
                imem_req_valid = !redirect_valid && (credit_used < (CW+1)'(DEPTH));
            end
            default: state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_next       = pc_reg;
        inflight_next = inflight_reg + CW'(req_fire) - CW'(rsp_seen);
        drop_next     = drop_reg;
        if (redirect_valid) begin
            pc_next   = align_word(redirect_pc);
            // No request fires on a redirect cycle, and a response landing in
            // this cycle is already discarded, so everything still in flight
            // afterwards belongs to the wrong path.
            drop_next = inflight_next;
        end else begin
            if (req_fire) pc_next = pc_reg + 32'd4;
            if (rsp_drop) drop_next = drop_reg - 1'b1;
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc_reg),
        .pop       (rsp_accept),
        .head_data (pend_head),
        .full      (pend_full),
        .empty     (pend_empty),
        .count     (pend_count)
    );

    assign obuf_push_data = '{pc: pend_head, instr: imem_rsp_data};
    // A downstream pop in the redirect cycle is honoured; the flush then
    // clears whatever remains.
    assign obuf_pop       = out_valid && out_ready;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_accept),
        .push_data (obuf_push_data),
        .pop       (obuf_pop),
        .head_data (obuf_head),
        .full      (obuf_full),
        .empty     (obuf_empty),
        .count     (obuf_count)
    );

    assign out_valid = !obuf_empty;
    assign out_pc    = obuf_empty ? 32'h0000_0000 : obuf_head.pc;
    assign out_instr = obuf_empty ? NOP_INSTR     : obuf_head.instr;

    // Status outputs that the credit scheme makes redundant here.
    assign unused_status = &{1'b0, pend_full, pend_empty, pend_count, obuf_full};

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int n_checks = 0;
    int n_fail   = 0;

    logic        mem_rsp_en = 1'b0;
    logic [31:0] mem_q[$];
    logic [31:0] req_log[$];
    logic [63:0] got_q[$];

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is its address XOR a fixed pattern.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model and output monitor, both on the falling edge. A response is
    // chosen from requests accepted at earlier rising edges, so latency is >= 1.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            if (mem_rsp_en && mem_q.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_of(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back(imem_req_addr);
                req_log.push_back(imem_req_addr);
                $display("tb: req  addr=%08h", imem_req_addr);
            end
            if (out_valid && out_ready) begin
                got_q.push_back({out_pc, out_instr});
                $display("tb: out  pc=%08h instr=%08h", out_pc, out_instr);
            end
        end
    end

    task automatic wait_got(input int need, input string name);
        for (int c = 0; c < 80 && got_q.size() < need; c++) @(negedge clk);
        #1;
        n_checks++;
        if (got_q.size() < need) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d outputs, required %0d", name, got_q.size(), need);
        end
    endtask

    task automatic quiesce();
        @(posedge clk); #1;
        imem_req_ready = 1'b0; mem_rsp_en = 1'b1; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_req_ready = 1'b1; mem_rsp_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b required 0", imem_req_valid); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %08h required 00000000", out_pc); end
        n_checks++; if (out_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_out_instr: got %08h required 00000013", out_instr); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_no_req: got %b required 0", imem_req_valid); end
        @(posedge clk); #1;
        n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL run_first_req: got %b required 1", imem_req_valid); end
        n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL run_first_addr: got %08h required 00000000", imem_req_addr); end
    endtask

    task automatic test_stream();
        wait_got(4, "stream");
        if (got_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_q[i] !== {32'(4*i), word_of(32'(4*i))}) begin
                    n_fail++;
                    $display("FAIL stream_out[%0d]: got %016h required %08h%08h", i, got_q[i], 32'(4*i), word_of(32'(4*i)));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (req_log[i] !== 32'(4*i)) begin n_fail++; $display("FAIL stream_req[%0d]: got %08h required %08h", i, req_log[i], 32'(4*i)); end
        end
    endtask

    task automatic test_stall();
        int pops0, bad, max_out;
        logic [31:0] held;
        @(posedge clk); #1;
        out_ready = 1'b0;
        pops0 = got_q.size();
        bad = 0; max_out = 0;
        repeat (2) @(negedge clk);
        #1;
        held = out_pc;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (!out_valid || out_pc !== held) bad++;
            if (req_log.size() - got_q.size() > max_out) max_out = req_log.size() - got_q.size();
        end
        n_checks++; if (held !== 32'(4*pops0)) begin n_fail++; $display("FAIL stall_head_pc: got %08h required %08h", held, 32'(4*pops0)); end
        n_checks++; if (out_instr !== word_of(32'(4*pops0))) begin n_fail++; $display("FAIL stall_head_instr: got %08h required %08h", out_instr, word_of(32'(4*pops0))); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles required 0", bad); end
        n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL stall_credit: got %0d outstanding required <= 2", max_out); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_got(pops0 + 4, "stall_release");
        if (got_q.size() >= pops0 + 4) begin
            for (int i = pops0; i < pops0 + 4; i++) begin
                n_checks++;
                if (got_q[i] !== {32'(4*i), word_of(32'(4*i))}) begin
                    n_fail++;
                    $display("FAIL stall_seq[%0d]: got %016h required %08h%08h", i, got_q[i], 32'(4*i), word_of(32'(4*i)));
                end
            end
        end
    endtask

    task automatic test_redirect();
        int nreq, ngot;
        @(posedge clk); #1;
        mem_rsp_en = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_pre_empty: got %b required 0", out_valid); end
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        nreq = req_log.size(); ngot = got_q.size();
        @(negedge clk); #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_no_req: got %b required 0", imem_req_valid); end
        @(posedge clk); #1;
        redirect_valid = 1'b0; mem_rsp_en = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_post_empty: got %b required 0", out_valid); end
        wait_got(ngot + 2, "redir");
        n_checks++; if (req_log[nreq] !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_req_addr: got %08h required 00000100", req_log[nreq]); end
        if (got_q.size() >= ngot + 2) begin
            n_checks++; if (got_q[ngot] !== {32'h0000_0100, word_of(32'h100)}) begin n_fail++; $display("FAIL redir_out0: got %016h required %08h%08h", got_q[ngot], 32'h100, word_of(32'h100)); end
            n_checks++; if (got_q[ngot+1] !== {32'h0000_0104, word_of(32'h104)}) begin n_fail++; $display("FAIL redir_out1: got %016h required %08h%08h", got_q[ngot+1], 32'h104, word_of(32'h104)); end
        end
    endtask

    // Redirect in the same cycle as a downstream pop and a response.
    task automatic test_redirect_pop_rsp();
        int ngot;
        quiesce();
        mem_rsp_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(posedge clk); #1;
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_rsp_en = 1'b1;
        @(posedge clk); #1;
        ngot = got_q.size();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL coinc_no_stale: got %b required 0", out_valid); end
        wait_got(ngot + 2, "coinc");
        if (got_q.size() >= ngot + 2) begin
            n_checks++; if (got_q[ngot] !== {32'h0000_0200, word_of(32'h200)}) begin n_fail++; $display("FAIL coinc_popped: got %016h required %08h%08h", got_q[ngot], 32'h200, word_of(32'h200)); end
            n_checks++; if (got_q[ngot+1] !== {32'h0000_0300, word_of(32'h300)}) begin n_fail++; $display("FAIL coinc_next: got %016h required %08h%08h", got_q[ngot+1], 32'h300, word_of(32'h300)); end
        end
    endtask

    // Two in flight, one returns in the redirect cycle: exactly one more is dropped.
    task automatic test_redirect_drop_count();
        int ngot;
        quiesce();
        mem_rsp_en = 1'b0; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        @(posedge clk); #1;
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_rsp_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        ngot = got_q.size();
        wait_got(ngot + 1, "drop");
        if (got_q.size() >= ngot + 1) begin
            n_checks++; if (got_q[ngot] !== {32'h0000_0500, word_of(32'h500)}) begin n_fail++; $display("FAIL drop_next: got %016h required %08h%08h", got_q[ngot], 32'h500, word_of(32'h500)); end
        end
    endtask

    task automatic test_wrap();
        int nreq, ngot;
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        nreq = req_log.size();
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        ngot = got_q.size();
        wait_got(ngot + 2, "wrap");
        n_checks++; if (req_log[nreq] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req0: got %08h required fffffffc", req_log[nreq]); end
        n_checks++; if (req_log[nreq+1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_req1: got %08h required 00000000", req_log[nreq+1]); end
        if (got_q.size() >= ngot + 2) begin
            n_checks++; if (got_q[ngot][63:32] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_out0: got %08h required fffffffc", got_q[ngot][63:32]); end
            n_checks++; if (got_q[ngot+1] !== {32'h0, word_of(32'h0)}) begin n_fail++; $display("FAIL wrap_out1: got %016h required 00000000%08h", got_q[ngot+1], word_of(32'h0)); end
        end
    endtask

    task automatic test_reset_midop();
        int ngot;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b required 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid: got %b required 0", imem_req_valid); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_out_pc: got %08h required 00000000", out_pc); end
        n_checks++; if (out_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL midrst_out_instr: got %08h required 00000013", out_instr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        ngot = got_q.size();
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_boot: got %b required 0", imem_req_valid); end
        @(posedge clk); #1;
        n_checks++; if (imem_req_addr !== 32'h0 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_first_req: got valid=%b addr=%08h required valid=1 addr=00000000", imem_req_valid, imem_req_addr); end
        wait_got(ngot + 2, "midrst");
        if (got_q.size() >= ngot + 2) begin
            n_checks++; if (got_q[ngot] !== {32'h0, word_of(32'h0)}) begin n_fail++; $display("FAIL midrst_out0: got %016h required 00000000%08h", got_q[ngot], word_of(32'h0)); end
            n_checks++; if (got_q[ngot+1] !== {32'h4, word_of(32'h4)}) begin n_fail++; $display("FAIL midrst_out1: got %016h required 00000004%08h", got_q[ngot+1], word_of(32'h4)); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop_rsp();
        test_redirect_drop_count();
        test_wrap();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
